axi4_lite_reg_slave: RTL and testbench
======================================

# axi4_lite_reg_slave

AXI4-Lite slave exposing a small memory-mapped register file: control, TX/RX data with internal loopback, IRQ enable, scratch and a read-only version word. It sits behind an AXI4-Lite interconnect port as the reference peripheral of the protocol suite. Writes honour byte strobes, and out-of-range accesses return SLVERR.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset, asynchronous, active-high
- awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; awready  out  1  write-address channel; awprot ignored
- wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1; wready  out  1  write-data channel
- bresp  out  2; bvalid  out  1; bready  in  1  write-response channel
- araddr/arprot/arvalid  in  ADDR_WIDTH/3/1; arready  out  1  read-address channel; arprot ignored
- rdata  out  DATA_WIDTH; rresp  out  2; rvalid  out  1; rready  in  1  read-data channel
- Signals are grouped by the axi4_lite_if bundle, slave modport, as decided: one clock; reset is asynchronous and active-high.

## Operation
- Register map (byte offsets, addr[1:0] ignored):
  - CTRL 0x00 RW
  - DATA_TX 0x04 RW
  - DATA_RX 0x08 RO
  - IRQ_EN 0x0C RW
  - SCRATCH 0x10 RW
  - VERSION 0x14 RO = IP_VERSION (32'h0001_0000)
  - 0x18 and 0x1C reserved: read 0, writes ignored, OKAY.
- Address decode: any nonzero bit in addr[ADDR_WIDTH-1:5] → SLVERR (2'b10). No register changes on SLVERR writes. SLVERR reads return rdata=0.
- All in-range accesses return OKAY (2'b00), including writes to RO registers; such writes are silently dropped.
- WSTRB: byte lane i of the target updates only when wstrb[i]=1. wstrb=0 is a legal no-op with OKAY.
- Loopback: DATA_RX is a register loaded from DATA_TX every cycle, so it trails DATA_TX by one clock.
- Reset values: all RW registers and DATA_RX = 0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; awready=wready=arready=0.

## Timing
- awready, wready and arready are registered and rise the first cycle after reset deasserts. They assert before VALID.
- AW and W are accepted independently, in either order and with any gap:
  - AW handshake latches the address and drops awready.
  - W handshake latches data and strobes and drops wready.
  - Each stays low until the B handshake completes.
- Register update happens in the cycle after both AW and W are latched. bvalid rises in that same cycle with bresp. Simultaneous AW+W gives bvalid 1 cycle after the handshake edge.
- bvalid holds, with bresp stable, until bready. After the B handshake, awready and wready re-assert next cycle. Only one write is outstanding.
- Read: AR handshake drops arready. The next cycle, rvalid=1 with registered rdata/rresp, held stable until rready. arready re-asserts the cycle after the R handshake.
- Read and write paths are independent and may be active at once. A read of a register written in the same cycle returns the old value.
- Reset mid-transaction aborts it: all VALID/READY outputs clear immediately and register contents reset.

## Structure
- axi_pkg holds:
  - RESP_OKAY/RESP_EXOKAY/RESP_SLVERR/RESP_DECERR
  - REG_*_OFFSET constants for CTRL, DATA_TX, DATA_RX, IRQ_EN, SCRATCH, VERSION
  - IP_VERSION
- axi4_lite_if is the parameterised signal bundle with master/slave modports.
- The slave is a single module with three pieces: write FSM (IDLE, HAVE_AW, HAVE_W, RESP), read FSM (IDLE, RESP), and register file/decode. No further sub-modules.

## Test plan
- After reset, read 0x14 → 32'h0001_0000 OKAY; read 0x00 → 0 OKAY.
- Write 0x00=CAFEBABE, 0x10=DEADBEEF, strb 1111 → OKAY; read-back equal. Write 0x04=12345678 → read 0x04 and, 3 cycles later, 0x08 both 12345678.
- Write 0x14=FFFFFFFF → OKAY, VERSION unchanged.
- SCRATCH=AABBCCDD:
  - write 11111111 strb 0001 → AABBCC11
  - then FF00FF00 strb 1100 → FF00CC11
- Write/read 0x100 → bresp/rresp SLVERR.
- AW then W 2 cycles later (AAAA1111), W then AW 3 cycles later (BBBB2222) → OKAY and correct read-back. Back-to-back writes 1..4 → SCRATCH=4. Three consecutive reads return identical data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes, register offsets and FSM state types
// for the register-slave peripheral.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [4:0] REG_CTRL_OFFSET    = 5'h00;
  localparam logic [4:0] REG_DATA_TX_OFFSET = 5'h04;
  localparam logic [4:0] REG_DATA_RX_OFFSET = 5'h08;
  localparam logic [4:0] REG_IRQ_EN_OFFSET  = 5'h0C;
  localparam logic [4:0] REG_SCRATCH_OFFSET = 5'h10;
  localparam logic [4:0] REG_VERSION_OFFSET = 5'h14;

  localparam logic [31:0] IP_VERSION = 32'h0001_0000;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// Parameterised AXI4-Lite signal bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic aclk,
  input logic areset
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  aclk, areset,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, areset,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: CTRL, DATA_TX, DATA_RX (loopback of DATA_TX),
// IRQ_EN, SCRATCH and a read-only VERSION word.
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both high; VALID is held with stable payload
// until then, and the slave's READY is a registered output.
module axi4_lite_reg_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [1:0]            dbg_wr_state,
  output logic                  dbg_rd_state
);

  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_fire, wr_err;

  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_err;

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d, tx_q, tx_d, rx_q, rx_d;
  logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d, scratch_q, scratch_d;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_val;
  logic [4:0]            wr_off, rd_off;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_bits;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign b_hs  = bvalid_q & bready;
  assign ar_hs = arvalid & arready_q;
  assign r_hs  = rvalid_q & rready;

  // Write FSM: latch AW and W independently, fire the register update and
  // raise bvalid on the edge where the second of the two is accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_fire    = 1'b0;
    if (aw_hs) awaddr_d = awaddr;
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_d = WR_RESP;
          wr_fire    = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: if (w_hs) begin
        wr_state_d = WR_RESP;
        wr_fire    = 1'b1;
      end
      WR_HAVE_W: if (aw_hs) begin
        wr_state_d = WR_RESP;
        wr_fire    = 1'b1;
      end
      WR_RESP: if (b_hs) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    wr_err = |awaddr_d[ADDR_WIDTH-1:5];
    if (wr_fire) bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Register file: strobe-merged write into the addressed RW register;
  // DATA_RX follows DATA_TX one clock later.
  always_comb begin
    ctrl_d    = ctrl_q;
    tx_d      = tx_q;
    rx_d      = tx_q;
    irq_en_d  = irq_en_q;
    scratch_d = scratch_q;
    wr_off    = {awaddr_d[4:2], 2'b00};
    case (wr_off)
      REG_CTRL_OFFSET:    wr_old = ctrl_q;
      REG_DATA_TX_OFFSET: wr_old = tx_q;
      REG_IRQ_EN_OFFSET:  wr_old = irq_en_q;
      REG_SCRATCH_OFFSET: wr_old = scratch_q;
      default:            wr_old = '0;
    endcase
    wr_merged = wr_old;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wstrb_d[i]) wr_merged[i*8 +: 8] = wdata_d[i*8 +: 8];
    end
    if (wr_fire && !wr_err) begin
      case (wr_off)
        REG_CTRL_OFFSET:    ctrl_d    = wr_merged;
        REG_DATA_TX_OFFSET: tx_d      = wr_merged;
        REG_IRQ_EN_OFFSET:  irq_en_d  = wr_merged;
        REG_SCRATCH_OFFSET: scratch_d = wr_merged;
        default: ;
      endcase
    end
  end

  // Read FSM: capture decoded data on the AR handshake, hold until R handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_off     = {araddr[4:2], 2'b00};
    rd_err     = |araddr[ADDR_WIDTH-1:5];
    case (rd_off)
      REG_CTRL_OFFSET:    rd_val = ctrl_q;
      REG_DATA_TX_OFFSET: rd_val = tx_q;
      REG_DATA_RX_OFFSET: rd_val = rx_q;
      REG_IRQ_EN_OFFSET:  rd_val = irq_en_q;
      REG_SCRATCH_OFFSET: rd_val = scratch_q;
      REG_VERSION_OFFSET: rd_val = DATA_WIDTH'(IP_VERSION);
      default:            rd_val = '0;
    endcase
    case (rd_state_q)
      RD_IDLE: if (ar_hs) begin
        rd_state_d = RD_RESP;
        rdata_d    = rd_err ? '0 : rd_val;
        rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      RD_RESP: if (r_hs) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_RESP);
  end

  // State and register flops; reset aborts any transaction in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      ctrl_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      irq_en_q   <= '0;
      scratch_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ctrl_q     <= ctrl_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      irq_en_q   <= irq_en_d;
      scratch_q  <= scratch_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign dbg_wr_state = wr_state_q;
  assign dbg_rd_state = rd_state_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = &{1'b0, awprot, arprot, awaddr_d[1:0], araddr[1:0]};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: table of single accesses plus
// hand-written sequences for channel ordering, loopback and reset.
module tb_axi4_lite_reg_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp, dbg_wr_state;
  logic        dbg_rd_state;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  axi4_lite_reg_slave dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // Clock
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  // Drive one write; AW and W become valid after their own cycle delays.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    int t;
    bit aw_done, w_done, hs_aw, hs_w;
    t = 0; aw_done = 0; w_done = 0; resp = 2'bxx; lat = -1;
    while (!(aw_done && w_done) && t < 100) begin
      @(negedge aclk);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      #1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk);
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      t++;
    end
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail("write addr/data");
      return;
    end
    bready = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (bvalid) begin
        lat  = c;
        resp = bresp;
        break;
      end
      @(negedge aclk);
    end
    if (lat < 0) timeout_fail("write resp");
    @(posedge aclk);
    #1 bready = 1'b0;
  endtask

  // Drive one read; rready is held low for rr_dly cycles after rvalid.
  task automatic axi_read(input logic [31:0] addr, input int rr_dly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
    int t;
    bit done, hs;
    t = 0; done = 0; lat = -1; data = 'x; resp = 2'bxx;
    while (!done && t < 100) begin
      @(negedge aclk);
      araddr  = addr;
      arvalid = 1'b1;
      #1 hs = arready;
      @(posedge aclk);
      done = hs;
      t++;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    if (!done) begin
      timeout_fail("read addr");
      return;
    end
    for (int c = 1; c <= 100; c++) begin
      if (rvalid) begin
        lat  = c;
        data = rdata;
        resp = rresp;
        break;
      end
      @(negedge aclk);
    end
    if (lat < 0) begin
      timeout_fail("read data");
      return;
    end
    for (int k = 0; k < rr_dly; k++) begin
      @(negedge aclk);
      chk("rvalid hold", {31'b0, rvalid}, 32'h1);
      chk("rdata hold", rdata, data);
    end
    rready = 1'b1;
    @(posedge aclk);
    #1 rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data, d0, d1, d2;
    int          lat;

    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("reset awready", {31'b0, awready}, 32'h0);
    chk("reset wready", {31'b0, wready}, 32'h0);
    chk("reset arready", {31'b0, arready}, 32'h0);
    chk("reset bvalid", {31'b0, bvalid}, 32'h0);
    chk("reset rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset bresp/rresp", {28'b0, bresp, rresp}, 32'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("ready after reset", {29'b0, awready, wready, arready}, 32'h7);

    // Single-access vector table
    vecs.push_back({1'b0, 32'h14,  32'h0,        4'h0, 32'h0001_0000, 2'b00});
    vecs.push_back({1'b0, 32'h00,  32'h0,        4'h0, 32'h0,         2'b00});
    vecs.push_back({1'b1, 32'h00,  32'hCAFEBABE, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h00,  32'h0,        4'h0, 32'hCAFEBABE,  2'b00});
    vecs.push_back({1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF,  2'b00});
    vecs.push_back({1'b1, 32'h14,  32'hFFFFFFFF, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h14,  32'h0,        4'h0, 32'h0001_0000, 2'b00});
    vecs.push_back({1'b1, 32'h10,  32'hAABBCCDD, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b1, 32'h10,  32'h11111111, 4'h1, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h10,  32'h0,        4'h0, 32'hAABBCC11,  2'b00});
    vecs.push_back({1'b1, 32'h10,  32'hFF00FF00, 4'hC, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h10,  32'h0,        4'h0, 32'hFF00CC11,  2'b00});
    vecs.push_back({1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0,         2'b10});
    vecs.push_back({1'b0, 32'h100, 32'h0,        4'h0, 32'h0,         2'b10});
    vecs.push_back({1'b0, 32'h00,  32'h0,        4'h0, 32'hCAFEBABE,  2'b00});
    vecs.push_back({1'b1, 32'h0C,  32'h000000A5, 4'h0, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h0C,  32'h0,        4'h0, 32'h0,         2'b00});
    vecs.push_back({1'b1, 32'h0D,  32'h0000005A, 4'h1, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h0E,  32'h0,        4'h0, 32'h0000005A,  2'b00});
    vecs.push_back({1'b1, 32'h18,  32'hFFFFFFFF, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h18,  32'h0,        4'h0, 32'h0,         2'b00});
    vecs.push_back({1'b1, 32'h08,  32'hFFFFFFFF, 4'hF, 32'h0,         2'b00});
    vecs.push_back({1'b0, 32'h08,  32'h0,        4'h0, 32'h0,         2'b00});

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, 0, resp, lat);
        chk($sformatf("vec%0d bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        chk($sformatf("vec%0d b latency", i), lat, 32'd1);
      end else begin
        axi_read(vecs[i].addr, 0, data, resp, lat);
        chk($sformatf("vec%0d rdata", i), data, vecs[i].exp_data);
        chk($sformatf("vec%0d rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        chk($sformatf("vec%0d r latency", i), lat, 32'd1);
      end
    end

    // Loopback: DATA_TX then DATA_RX a few cycles later
    axi_write(32'h04, 32'h12345678, 4'hF, 0, 0, resp, lat);
    chk("tx write bresp", {30'b0, resp}, 32'h0);
    axi_read(32'h04, 0, data, resp, lat);
    chk("tx readback", data, 32'h12345678);
    repeat (3) @(posedge aclk);
    axi_read(32'h08, 0, data, resp, lat);
    chk("rx loopback", data, 32'h12345678);
    chk("rx rresp", {30'b0, resp}, 32'h0);

    // AW first, W two cycles later
    axi_write(32'h10, 32'hAAAA1111, 4'hF, 0, 2, resp, lat);
    chk("aw-first bresp", {30'b0, resp}, 32'h0);
    chk("aw-first b latency", lat, 32'd1);
    axi_read(32'h10, 0, data, resp, lat);
    chk("aw-first readback", data, 32'hAAAA1111);

    // W first, AW three cycles later
    axi_write(32'h00, 32'hBBBB2222, 4'hF, 3, 0, resp, lat);
    chk("w-first bresp", {30'b0, resp}, 32'h0);
    chk("w-first b latency", lat, 32'd1);
    axi_read(32'h00, 0, data, resp, lat);
    chk("w-first readback", data, 32'hBBBB2222);

    // Back-to-back writes to SCRATCH
    for (int v = 1; v <= 4; v++) begin
      axi_write(32'h10, v, 4'hF, 0, 0, resp, lat);
      chk($sformatf("b2b write %0d bresp", v), {30'b0, resp}, 32'h0);
    end

    // Three consecutive reads, one with a delayed rready
    axi_read(32'h10, 0, d0, resp, lat);
    axi_read(32'h10, 2, d1, resp, lat);
    axi_read(32'h10, 0, d2, resp, lat);
    chk("b2b final scratch", d0, 32'h4);
    chk("repeat read 2", d1, 32'h4);
    chk("repeat read 3", d2, 32'h4);

    // Reset in the middle of a write aborts it and clears registers
    @(negedge aclk);
    awaddr  = 32'h00;
    awvalid = 1'b1;
    #1 chk("mid awready pre", {31'b0, awready}, 32'h1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    chk("mid awready dropped", {30'b0, awready, wready}, 32'h1);
    areset = 1'b1;
    #1;
    chk("mid reset readies", {29'b0, awready, wready, arready}, 32'h0);
    chk("mid reset valids", {30'b0, bvalid, rvalid}, 32'h0);
    @(negedge aclk);
    areset = 1'b0;
    axi_read(32'h00, 0, data, resp, lat);
    chk("ctrl after reset", data, 32'h0);
    axi_read(32'h10, 0, data, resp, lat);
    chk("scratch after reset", data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
